// File: rtl/uart_frame_rx.sv
// uart_frame_rx: oversampled UART receiver with one-word holding register.
// Optional parity bit when UART_RX_PARITY_EN is defined (PARITY_ODD selects sense).
module uart_frame_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_RECOVER = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic       P_ODD     = PARITY_ODD[0];
`endif

  if (DATA_BITS < 5 || DATA_BITS > 9 ||
      CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_frame_rx: parameter out of range");
  end

  logic [1:0]           sync_q, sync_d;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 rxs;
  logic                 at_full;
  logic                 good;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 parbad_q, parbad_d;
`endif

  assign rxs     = sync_q[1];
  assign at_full = (timer_q == T_FULL);

  // Next-state: line sync, bit timing, framing and holding register.
  always_comb begin
    sync_d   = {sync_q[0], rx};
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    good     = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d   = 1'b0;
    parbad_d = parbad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          timer_d = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (timer_q == T_HALF) begin
          timer_d  = '0;
          bitcnt_d = '0;
          state_d  = rxs ? S_IDLE : S_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DATA: begin
        if (at_full) begin
          timer_d  = '0;
          shift_d  = {rxs, shift_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + CW'(1);
          if (bitcnt_q == C_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (at_full) begin
          timer_d  = '0;
          parbad_d = ((^shift_q) ^ rxs) != P_ODD;
          state_d  = S_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif
      S_STOP: begin
        if (at_full) begin
          timer_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (parbad_q) perr_d = 1'b1;
            else          good   = 1'b1;
`else
            good = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = S_RECOVER;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RECOVER: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (good) begin
      if (!valid_q || data_ready) begin
        dout_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q   <= 2'b11;
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q   <= 1'b0;
      parbad_q <= 1'b0;
`endif
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q   <= perr_d;
      parbad_q <= parbad_d;
`endif
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: table vectors, corner sequences and random frames
// checked against a frame-level model of the receiver.
module tb_uart_frame_rx;

  localparam int DB   = 8;
  localparam int CPB  = 16;
  localparam int PODD = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic          data_ready;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .DATA_BITS   (DB),
    .CLKS_PER_BIT(CPB),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_ready(data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int ov_cnt = 0;
  int vcyc   = 0;
  logic [DB-1:0] got_q[$];

  // Monitor: pulse counts and words handed to the consumer.
  always @(negedge clk) begin
    if (frame_err)  fe_cnt <= fe_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (overrun)    ov_cnt <= ov_cnt + 1;
    if (data_valid) vcyc   <= vcyc + 1;
    if (data_valid && data_ready) got_q.push_back(data_out);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) step();
  endtask

  task automatic send_bits(input logic [DB-1:0] d, input logic stopb);
    hold(1'b0, CPB);
    for (int i = 0; i < DB; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ PODD[0], CPB);
`endif
    hold(stopb, CPB);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stopb);
    send_bits(d, stopb);
    hold(1'b1, CPB);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_pframe(input logic [DB-1:0] d, input logic pbit);
    hold(1'b0, CPB);
    for (int i = 0; i < DB; i++) hold(d[i], CPB);
    hold(pbit, CPB);
    hold(1'b1, CPB);
    hold(1'b1, CPB);
  endtask
`endif

  typedef struct {
    logic [DB-1:0] d;
    logic          stopb;
    logic          rdy;
    logic          exp_valid;
    logic [DB-1:0] exp_dout;
    int            d_fe;
    int            d_ov;
    int            n_got;
    logic [DB-1:0] last_got;
    int            exp_vc;
  } vec_t;

  vec_t tbl[5];

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int fe0, pe0, ov0, vc0, g0;
    int exp_fe, exp_ov;
    bit saw_busy, full;
    logic [DB-1:0] d, held;
    logic sb;
    logic [DB-1:0] exp_q[$];

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1, 8'hA5, 1};
    tbl[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, 1, 0, 0, 8'h00, 0};
    tbl[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 0, 0, 0, 8'h00, -1};
    tbl[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 0, 1, 0, 8'h00, -1};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 2, 8'h5A, 2};

    rx = 1'b1;
    reset = 1'b0;
    data_ready = 1'b0;
    repeat (3) step();
    chk("rst data_out", 32'(data_out), 0);
    chk("rst data_valid", 32'(data_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst flags", {29'd0, frame_err, parity_err, overrun}, 0);
    reset = 1'b1;
    hold(1'b1, 4);

    for (int i = 0; i < 5; i++) begin
      data_ready = tbl[i].rdy;
      fe0 = fe_cnt; ov0 = ov_cnt; vc0 = vcyc; g0 = got_q.size();
      send_frame(tbl[i].d, tbl[i].stopb);
      chk($sformatf("vec%0d valid", i), 32'(data_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid)
        chk($sformatf("vec%0d data_out", i), 32'(data_out), 32'(tbl[i].exp_dout));
      chk($sformatf("vec%0d frame_err", i), fe_cnt - fe0, tbl[i].d_fe);
      chk($sformatf("vec%0d overrun", i), ov_cnt - ov0, tbl[i].d_ov);
      chk($sformatf("vec%0d n_got", i), got_q.size() - g0, tbl[i].n_got);
      if (tbl[i].n_got > 0 && got_q.size() > 0)
        chk($sformatf("vec%0d word", i), 32'(got_q[$]), 32'(tbl[i].last_got));
      if (tbl[i].exp_vc >= 0)
        chk($sformatf("vec%0d valid_cycles", i), vcyc - vc0, tbl[i].exp_vc);
    end

    // Glitch shorter than half a bit is a false start.
    data_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = vcyc;
    hold(1'b0, 4);
    rx = 1'b1;
    saw_busy = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (busy) saw_busy = 1;
    end
    chk("glitch busy_seen", 32'(saw_busy), 1);
    chk("glitch busy_end", 32'(busy), 0);
    chk("glitch valid", vcyc - vc0, 0);
    chk("glitch flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // Bad stop bit followed by a held-low break.
    fe0 = fe_cnt; vc0 = vcyc;
    send_bits(8'h3C, 1'b0);
    hold(1'b0, 40);
    chk("break busy_low", 32'(busy), 1);
    chk("break frame_err", fe_cnt - fe0, 1);
    chk("break valid", vcyc - vc0, 0);
    rx = 1'b1;
    for (int i = 0; i < 10 && busy; i++) step();
    chk("break busy_release", 32'(busy), 0);
    hold(1'b1, CPB);
    chk("break single_pulse", fe_cnt - fe0, 1);

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt; g0 = got_q.size(); vc0 = vcyc;
    send_pframe(8'h03, 1'b1);
    chk("par bad parity_err", pe_cnt - pe0, 1);
    chk("par bad valid", vcyc - vc0, 0);
    pe0 = pe_cnt;
    send_pframe(8'h03, 1'b0);
    chk("par good parity_err", pe_cnt - pe0, 0);
    chk("par good n_got", got_q.size() - g0, 1);
    if (got_q.size() > 0) chk("par good word", 32'(got_q[$]), 32'h03);
`endif

    // Random frames, consumer always ready.
    data_ready = 1'b1;
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    exp_fe = 0;
    for (int i = 0; i < 20; i++) begin
      d  = DB'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      if (sb) exp_q.push_back(d);
      else    exp_fe++;
      send_frame(d, sb);
    end
    chk("rand count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rand word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    chk("rand frame_err", fe_cnt - fe0, exp_fe);
    chk("rand overrun", ov_cnt - ov0, 0);
    chk("rand parity_err", pe_cnt - pe0, 0);

    // Random frames into a stalled consumer: first good word is kept.
    data_ready = 1'b0;
    g0 = got_q.size(); ov0 = ov_cnt;
    full = 0; exp_ov = 0; held = '0;
    for (int i = 0; i < 6; i++) begin
      d  = DB'($urandom);
      sb = ($urandom_range(0, 4) != 0);
      if (sb) begin
        if (!full) begin
          full = 1;
          held = d;
        end else begin
          exp_ov++;
        end
      end
      send_frame(d, sb);
    end
    chk("stall valid", 32'(data_valid), 32'(full));
    chk("stall overrun", ov_cnt - ov0, exp_ov);
    data_ready = 1'b1;
    repeat (3) step();
    chk("stall drain n_got", got_q.size() - g0, full ? 1 : 0);
    if (full && got_q.size() > g0) chk("stall drain word", 32'(got_q[$]), 32'(held));
    chk("stall drain valid", 32'(data_valid), 0);

    // Reset pulse in the middle of data bit 4 of 0xFF.
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; g0 = got_q.size();
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(1'b1, CPB);
    hold(1'b1, 8);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst data_out", 32'(data_out), 0);
    chk("midrst valid", 32'(data_valid), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst flags", {29'd0, frame_err, parity_err, overrun}, 0);
    hold(1'b1, 8 + 5 * CPB);
    chk("midrst no_flags", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
    chk("midrst no_word", got_q.size() - g0, 0);
    send_frame(8'h5A, 1'b1);
    chk("postrst n_got", got_q.size() - g0, 1);
    if (got_q.size() > g0) chk("postrst word", 32'(got_q[$]), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; legal range 4..65535.
REQ-003 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only when UART_RX_PARITY_EN is defined.
REQ-004 SHALL have port clk, input, 1: the single clock; every flop on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port rx, input, 1: asynchronous serial line; idle high, LSB first.
REQ-007 SHALL have port data_ready, input, 1: consumer accepts data_out this cycle.
REQ-008 SHALL have port data_out, output, DATA_BITS: received word.
REQ-009 SHALL have port data_valid, output, 1: data_out holds an unconsumed word.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse when a stop bit is sampled low.
REQ-011 SHALL have port parity_err, output, 1: one-cycle pulse on parity mismatch.
REQ-012 SHALL have port overrun, output, 1: one-cycle pulse when a good frame is dropped.
REQ-013 SHALL have port busy, output, 1: high in every state other than IDLE.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer (reset value 1); all further rules use the synchronized value rxs.
REQ-015 SHALL implement the states IDLE, START, DATA, PARITY, STOP and RECOVER.
REQ-016 IDLE: on rxs=0, SHALL clear the bit-timer and go to START.
REQ-017 START: at timer = CLKS_PER_BIT/2-1 (mid start bit), SHALL sample rxs; 1 = false start, go to IDLE with no flags; 0 = restart the timer and go to DATA.
REQ-018 DATA: SHALL sample rxs each time the timer reaches CLKS_PER_BIT-1, shift it into bit index 0 first, and leave after DATA_BITS samples for PARITY (macro defined) or STOP (macro undefined).
REQ-019 PARITY: SHALL sample one bit at mid-bit and record a mismatch against the parity computed over the data bits.
REQ-020 STOP: SHALL sample at mid-bit; rxs=1 completes the frame and goes to IDLE; rxs=0 pulses frame_err, discards the word and goes to RECOVER.
REQ-021 RECOVER: SHALL stay until rxs=1, then go to IDLE, so a held-low (break) line does not retrigger reception.
REQ-022 A parity-mismatched frame SHALL pulse parity_err in the stop-sample cycle, be discarded and never load data_out; frame_err takes precedence if both apply.
REQ-023 A good frame SHALL load data_out and set data_valid on the cycle after the stop sample.
REQ-024 data_out and data_valid SHALL hold until the cycle in which data_valid=1 and data_ready=1, after which data_valid clears unless REQ-025 applies.
REQ-025 If a good frame completes in the same cycle as a data_valid&&data_ready transfer, SHALL load the new word, keep data_valid=1 and not pulse overrun.
REQ-026 If a good frame completes while data_valid=1 and data_ready=0, SHALL keep the old word, drop the new one and pulse overrun.
REQ-027 The bit-timer SHALL be $clog2(CLKS_PER_BIT) wide and wrap to 0 at CLKS_PER_BIT-1; the bit counter SHALL be $clog2(DATA_BITS+1) wide.

Reset
REQ-028 While reset=0 at a clk edge: state=IDLE, timers=0, shift register=0, data_out=0, data_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, synchronizer=1.
REQ-029 Reset mid-frame SHALL abandon the frame with no flag; reception SHALL restart only on a new falling edge after reset deasserts.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, SHALL receive and check one parity bit per PARITY_ODD.
REQ-031 Without UART_RX_PARITY_EN: no PARITY state, no parity logic, parity_err tied to 0, and a frame is start + DATA_BITS + stop.

Verification (DATA_BITS=8, CLKS_PER_BIT=16 unless stated)
REQ-032 Frame 0xA5 with data_ready=1 -> data_out=0xA5, data_valid high 1 cycle; frame_err, parity_err and overrun stay 0.
REQ-033 rx low for 4 cycles then high -> busy pulses and returns 0; data_valid, frame_err and overrun stay 0.
REQ-034 Frame 0x3C with stop bit 0, then rx held low 40 cycles -> one frame_err pulse, data_valid=0, busy high until rx returns 1.
REQ-035 data_ready=0, frames 0x11 then 0x22 -> data_out=0x11 stays valid, one overrun pulse; then data_ready=1 -> data_valid clears.
REQ-036 Macro defined, PARITY_ODD=0, frame 0x03 with parity bit 1 -> one parity_err pulse, data_valid stays 0; with parity bit 0 -> data_out=0x03.
REQ-037 reset=0 asserted for 1 cycle at data bit 4 of frame 0xFF -> all outputs 0 afterwards, no flags; next frame 0x5A is received correctly.
